mdr_mar_mem_if: RTL and testbench
=================================

Name: mdr_mar_mem_if

Overview:
- Memory-side register stage for the mini CPU datapath.
- Holds the Memory Address Register (MAR) and the Memory Data Register (MDR), and runs the read/write handshake with the single-port RAM.
- The MDR value is the block's output and feeds the bus multiplexer's MDR input, so this block sits directly upstream of the bus.
- The MAR and MDR are loaded from the bus output under control-unit enables.

Parameters:
- ADDR_W, 9: MAR/RAM address width (512 words).
- DATA_W, 32: bus, MDR and RAM data width.
- TIMEOUT, 15: maximum cycles to wait for mem_ack (used only with MEM_TIMEOUT_EN).

Ports:
- clock  in  1  single clock; every register updates on its rising edge.
- clear  in  1  reset, asynchronous and active-high.
- BusMuxOut  in  DATA_W  bus value, the load source for MAR and MDR.
- MARin  in  1  load MAR from BusMuxOut[ADDR_W-1:0].
- MDRin  in  1  load MDR from BusMuxOut.
- MemRead  in  1  start a RAM read at MAR into MDR.
- MemWrite  in  1  start a RAM write of MDR to MAR.
- mem_req  out  1  RAM request, held until ack.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- mem_addr  out  ADDR_W  always equals MAR.
- mem_wdata  out  DATA_W  always equals MDR.
- mem_rdata  in  DATA_W  RAM read data, valid when mem_ack is high.
- mem_ack  in  1  RAM completion, one-cycle pulse.
- BusMuxInMDR  out  DATA_W  MDR contents to the bus mux.
- mem_busy  out  1  high in RD_WAIT and WR_WAIT.
- mem_done  out  1  one-cycle pulse after a transfer completes.
- mem_err  out  1  sticky timeout flag (MEM_TIMEOUT_EN only; tied 0 otherwise).

Behaviour:
- Reset (clear high, any time, asynchronous):
  - MAR = 0, MDR = 0, state = IDLE.
  - mem_req = 0, mem_we = 0, mem_done = 0, mem_err = 0, mem_busy = 0.
  - A reset in the middle of a transfer abandons it; no MDR update occurs.
- States: IDLE, RD_WAIT, WR_WAIT, DONE. All outputs are registered or decoded directly from the state.
- IDLE:
  - MARin loads MAR.
  - MDRin loads MDR.
  - MemRead=1 → RD_WAIT at the next edge, with mem_req=1 and mem_we=0 from that cycle.
  - MemWrite=1 → WR_WAIT, with mem_req=1 and mem_we=1.
  - MemRead and MemWrite together: the read wins and the write is dropped.
  - A MARin/MDRin arriving in the same cycle as a MemRead/MemWrite takes effect first; the request uses the newly loaded value.
  - mem_ack in IDLE is ignored.
- RD_WAIT:
  - Stays here while mem_ack=0.
  - On the edge where mem_ack=1: MDR ← mem_rdata, mem_req drops, → DONE.
  - Minimum read latency is 2 edges from MemRead to MDR valid (ack present on the first wait cycle).
- WR_WAIT:
  - On mem_ack=1: mem_req drops, → DONE. MDR and MAR are unchanged.
- DONE:
  - mem_done=1 for exactly this one cycle, then → IDLE.
  - MARin/MDRin are honoured in DONE.
  - MemRead/MemWrite in DONE are ignored; the control unit must reissue them in IDLE.
- While busy (RD_WAIT/WR_WAIT):
  - MARin, MDRin, MemRead and MemWrite are all ignored.
  - MAR and MDR stay stable, so mem_addr and mem_wdata are stable for the whole request.
- Output timing: BusMuxInMDR equals MDR combinationally, so a new MDR value is visible in the cycle after the loading edge.
- Widths: MAR takes the low ADDR_W bits of the bus; upper bus bits are discarded. The MDR is full DATA_W wide with no extension.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - A 4-bit-minimum counter, sized to hold TIMEOUT, clears on entry to RD_WAIT or WR_WAIT and increments each cycle without ack.
  - When the counter reaches TIMEOUT with no ack: mem_req drops, mem_err is set (sticky until clear), state → DONE, and mem_done pulses.
  - MDR is not updated on a timed-out read.
  - An ack arriving in the same cycle as the timeout counts as success: MDR loads and mem_err is not set.
- Not defined: the counter is absent, the block waits for ack indefinitely, and mem_err is a constant 0.

Test Plan:
- Reset: pulse clear asynchronously between edges → MAR=0, MDR=0, BusMuxInMDR=0, mem_req=0 immediately.
- Read: MARin with BusMuxOut=0x0000_0185, then MemRead; RAM acks on the 3rd wait cycle with 0xDEAD_BEEF → mem_addr=0x185, mem_we=0 throughout, MDR=0xDEAD_BEEF on the ack edge, mem_done high for 1 cycle.
- Write: MARin with 0x3F, MDRin with 0x1234_5678, MemWrite; ack on the 1st cycle → mem_we=1, mem_wdata=0x1234_5678, MDR is unchanged afterwards.
- Busy blocking: during RD_WAIT assert MDRin with 0xFFFF_FFFF and MARin with 0x0 → MDR ends at the RAM data, mem_addr is held at its old value.
- Conflict: MemRead and MemWrite asserted together → read cycle only, mem_we=0; reset asserted in WR_WAIT → IDLE, mem_req=0, MDR=0.
- MEM_TIMEOUT_EN: MemRead with ack never asserted → mem_req falls after 15 wait cycles, mem_err=1, MDR unchanged; ack on exactly cycle 15 → MDR loads, mem_err=0.

Source files
------------

// File: rtl/mdr_mar_mem_if_if.sv
// Bundle of control-unit, bus and RAM handshake signals for the MAR/MDR memory stage.
// master: the memory stage itself; slave: control unit / RAM side.
interface mdr_mar_mem_if_if #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
);
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              MemRead;
  logic              MemWrite;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] BusMuxInMDR;
  logic              mem_busy;
  logic              mem_done;
  logic              mem_err;

  modport master (
    input  BusMuxOut, MARin, MDRin, MemRead, MemWrite, mem_rdata, mem_ack,
    output mem_req, mem_we, mem_addr, mem_wdata, BusMuxInMDR, mem_busy, mem_done, mem_err
  );

  modport slave (
    output BusMuxOut, MARin, MDRin, MemRead, MemWrite, mem_rdata, mem_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata, BusMuxInMDR, mem_busy, mem_done, mem_err
  );
endinterface

// File: rtl/mdr_mar_mem_if.sv
// MAR/MDR register stage with a req/ack handshake to a single-port RAM.
// Optional MEM_TIMEOUT_EN: abandon a request after TIMEOUT un-acked wait cycles, set sticky mem_err.
module mdr_mar_mem_if #(
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input logic               clock,
  input logic               clear,
  mdr_mar_mem_if_if.master  bus
);

  typedef enum logic [1:0] {StIdle, StRdWait, StWrWait, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mdr_q;
  logic              req_q;
  logic              we_q;
  logic              done_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  logic [CntW-1:0] cnt_q;
  logic            err_q;
  logic            expired;

  // The cycle that would take the count to TIMEOUT is the last one an ack may arrive in.
  assign expired = (cnt_q == CntW'(TIMEOUT - 1));
`endif

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StIdle;
      mar_q   <= '0;
      mdr_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          // Loads land on the same edge as the request, so the request sees new values.
          if (bus.MARin) mar_q <= bus.BusMuxOut[ADDR_W-1:0];
          if (bus.MDRin) mdr_q <= bus.BusMuxOut;
          if (bus.MemRead) begin
            state_q <= StRdWait;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end else if (bus.MemWrite) begin
            state_q <= StWrWait;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        StRdWait, StWrWait: begin
          if (bus.mem_ack) begin
            if (state_q == StRdWait) mdr_q <= bus.mem_rdata;
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
          end else if (expired) begin
            state_q <= StDone;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
`endif
          end
        end
        StDone: begin
          if (bus.MARin) mar_q <= bus.BusMuxOut[ADDR_W-1:0];
          if (bus.MDRin) mdr_q <= bus.BusMuxOut;
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          we_q    <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req     = req_q;
  assign bus.mem_we      = we_q;
  assign bus.mem_addr    = mar_q;
  assign bus.mem_wdata   = mdr_q;
  assign bus.BusMuxInMDR = mdr_q;
  assign bus.mem_done    = done_q;
  assign bus.mem_busy    = (state_q == StRdWait) || (state_q == StWrWait);
`ifdef MEM_TIMEOUT_EN
  assign bus.mem_err     = err_q;
`else
  assign bus.mem_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mdr_mar_mem_if.sv
// Self-checking bench for mdr_mar_mem_if; expected MDR values flow through a scoreboard queue.
module tb_mdr_mar_mem_if;
  localparam int unsigned ADDR_W  = 9;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 15;

  logic clock = 1'b0;
  logic clear = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;

  mdr_mar_mem_if_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mdr_mar_mem_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    bus.BusMuxOut = '0;
    bus.MARin     = 1'b0;
    bus.MDRin     = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 32'h0BAD_0BAD;
  endtask

  // Advance to the next falling edge: outputs are sampled there, then inputs redriven.
  task automatic step();
    @(negedge clock);
  endtask

  task automatic load(input logic mar, input logic mdr, input logic [DATA_W-1:0] v);
    bus.BusMuxOut = v;
    bus.MARin     = mar;
    bus.MDRin     = mdr;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    clear = 1'b1;
    idle_inputs();
    step();
    n_checks++;
    if (bus.mem_addr !== '0 || bus.BusMuxInMDR !== '0 || bus.mem_req !== 1'b0 ||
        bus.mem_we !== 1'b0 || bus.mem_busy !== 1'b0 || bus.mem_done !== 1'b0 ||
        bus.mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h mdr=%h req=%b we=%b busy=%b done=%b err=%b, want all 0",
               bus.mem_addr, bus.BusMuxInMDR, bus.mem_req, bus.mem_we, bus.mem_busy,
               bus.mem_done, bus.mem_err);
    end
    clear = 1'b0;
    step();
    load(1'b1, 1'b1, 32'h0000_01AB);
    n_checks++;
    if (bus.mem_addr !== 9'h1AB || bus.BusMuxInMDR !== 32'h0000_01AB) begin
      n_fail++;
      $display("FAIL idle_load: addr=%h mdr=%h, want 1ab/000001ab", bus.mem_addr, bus.BusMuxInMDR);
    end
    #2 clear = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_addr !== '0 || bus.BusMuxInMDR !== '0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: addr=%h mdr=%h req=%b, want 0/0/0",
               bus.mem_addr, bus.BusMuxInMDR, bus.mem_req);
    end
    #1 clear = 1'b0;
    step();
  endtask

  task automatic test_read();
    load(1'b1, 1'b0, 32'h0000_0185);
    bus.MemRead = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    step();
    bus.MemRead = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 9'h185 ||
          bus.mem_busy !== 1'b1) begin
        n_fail++;
        $display("FAIL read_wait%0d: req=%b we=%b addr=%h busy=%b, want 1/0/185/1",
                 c, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_busy);
      end
      bus.mem_ack   = (c == 3);
      bus.mem_rdata = (c == 3) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;
      step();
    end
    idle_inputs();
    n_checks++;
    if (bus.mem_done !== 1'b1 || bus.mem_req !== 1'b0 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL read_done: done=%b req=%b pending=%0d, want 1/0/1",
               bus.mem_done, bus.mem_req, exp_q.size());
    end else begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.BusMuxInMDR !== exp_v) begin
        n_fail++;
        $display("FAIL read_data: got %h want %h", bus.BusMuxInMDR, exp_v);
      end
    end
    step();
    n_checks++;
    if (bus.mem_done !== 1'b0 || bus.mem_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL read_done_pulse: done=%b busy=%b, want 0/0", bus.mem_done, bus.mem_busy);
    end
  endtask

  task automatic test_write();
    load(1'b1, 1'b0, 32'h0000_003F);
    load(1'b0, 1'b1, 32'h1234_5678);
    bus.MemWrite = 1'b1;
    exp_q.push_back(32'h1234_5678);
    step();
    bus.MemWrite = 1'b0;
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 9'h03F ||
        bus.mem_wdata !== 32'h1234_5678) begin
      n_fail++;
      $display("FAIL write_wait: req=%b we=%b addr=%h wdata=%h, want 1/1/03f/12345678",
               bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFE_F00D;
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_done !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL write_done: done=%b pending=%0d, want 1/1", bus.mem_done, exp_q.size());
    end else begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.BusMuxInMDR !== exp_v || bus.mem_addr !== 9'h03F) begin
        n_fail++;
        $display("FAIL write_mdr_kept: mdr=%h addr=%h, want %h/03f",
                 bus.BusMuxInMDR, bus.mem_addr, exp_v);
      end
    end
    step();
  endtask

  // Loads in the request cycle must be visible to the request; MAR keeps only low bits.
  task automatic test_load_and_request();
    bus.BusMuxOut = 32'hFFFF_F0C3;
    bus.MARin     = 1'b1;
    bus.MDRin     = 1'b1;
    bus.MemWrite  = 1'b1;
    exp_q.push_back(32'hFFFF_F0C3);
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_we !== 1'b1 || bus.mem_addr !== 9'h0C3 || bus.mem_wdata !== 32'hFFFF_F0C3) begin
      n_fail++;
      $display("FAIL same_cycle_load: we=%b addr=%h wdata=%h, want 1/0c3/fffff0c3",
               bus.mem_we, bus.mem_addr, bus.mem_wdata);
    end
    bus.mem_ack = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_done !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL same_cycle_done: done=%b, want 1", bus.mem_done);
    end else begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.BusMuxInMDR !== exp_v) begin
        n_fail++;
        $display("FAIL same_cycle_mdr: got %h want %h", bus.BusMuxInMDR, exp_v);
      end
    end
    step();
  endtask

  task automatic test_busy_block();
    load(1'b1, 1'b0, 32'h0000_0155);
    bus.MemRead = 1'b1;
    exp_q.push_back(32'hA5A5_5A5A);
    step();
    idle_inputs();
    bus.BusMuxOut = 32'hFFFF_FFFF;
    bus.MDRin     = 1'b1;
    step();
    idle_inputs();
    bus.MARin    = 1'b1;
    bus.MemWrite = 1'b1;
    n_checks++;
    if (bus.mem_addr !== 9'h155 || bus.BusMuxInMDR !== 32'hFFFF_F0C3 || bus.mem_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold1: addr=%h mdr=%h busy=%b, want 155/fffff0c3/1",
               bus.mem_addr, bus.BusMuxInMDR, bus.mem_busy);
    end
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_addr !== 9'h155 || bus.mem_we !== 1'b0 || bus.mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_hold2: addr=%h we=%b req=%b, want 155/0/1",
               bus.mem_addr, bus.mem_we, bus.mem_req);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hA5A5_5A5A;
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_done !== 1'b1 || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL busy_done: done=%b, want 1", bus.mem_done);
    end else begin
      exp_v = exp_q.pop_front();
      n_checks++;
      if (bus.BusMuxInMDR !== exp_v || bus.mem_addr !== 9'h155) begin
        n_fail++;
        $display("FAIL busy_result: mdr=%h addr=%h, want %h/155", bus.BusMuxInMDR, bus.mem_addr, exp_v);
      end
    end
    step();
  endtask

  task automatic test_conflict();
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    exp_q.push_back(32'h0F0F_0F0F);
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_read_wins: req=%b we=%b, want 1/0", bus.mem_req, bus.mem_we);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0F0F_0F0F;
    step();
    idle_inputs();
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.mem_done !== 1'b1 || bus.BusMuxInMDR !== exp_v) begin
      n_fail++;
      $display("FAIL conflict_data: done=%b mdr=%h, want 1/%h", bus.mem_done, bus.BusMuxInMDR, exp_v);
    end
    step();
    // Reset in the middle of a write abandons it.
    bus.MemWrite = 1'b1;
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_wait_entry: req=%b we=%b, want 1/1", bus.mem_req, bus.mem_we);
    end
    #2 clear = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_busy !== 1'b0 || bus.BusMuxInMDR !== '0 ||
        bus.mem_we !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_in_write: req=%b busy=%b mdr=%h we=%b, want 0/0/0/0",
               bus.mem_req, bus.mem_busy, bus.BusMuxInMDR, bus.mem_we);
    end
    #1 clear = 1'b0;
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_done !== 1'b0 || bus.BusMuxInMDR !== '0 || bus.mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ack_ignored: done=%b mdr=%h req=%b, want 0/0/0",
               bus.mem_done, bus.BusMuxInMDR, bus.mem_req);
    end
  endtask

  task automatic test_done_state();
    bus.MemRead = 1'b1;
    step();
    idle_inputs();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h1111_2222;
    step();
    idle_inputs();
    // Two edges from MemRead: data already in the MDR.
    n_checks++;
    if (bus.BusMuxInMDR !== 32'h1111_2222 || bus.mem_done !== 1'b1) begin
      n_fail++;
      $display("FAIL min_latency: mdr=%h done=%b, want 11112222/1", bus.BusMuxInMDR, bus.mem_done);
    end
    bus.MemRead   = 1'b1;
    bus.MDRin     = 1'b1;
    bus.BusMuxOut = 32'h0000_0077;
    step();
    idle_inputs();
    n_checks++;
    if (bus.mem_busy !== 1'b0 || bus.mem_req !== 1'b0 || bus.BusMuxInMDR !== 32'h0000_0077) begin
      n_fail++;
      $display("FAIL done_state_rules: busy=%b req=%b mdr=%h, want 0/0/00000077",
               bus.mem_busy, bus.mem_req, bus.BusMuxInMDR);
    end
  endtask

  task automatic test_timeout();
    bus.MemRead = 1'b1;
    exp_q.push_back(32'h0000_0077);
    step();
    idle_inputs();
`ifdef MEM_TIMEOUT_EN
    for (int c = 1; c <= int'(TIMEOUT); c++) begin
      n_checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_err !== 1'b0) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: req=%b err=%b, want 1/0", c, bus.mem_req, bus.mem_err);
      end
      step();
    end
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.mem_req !== 1'b0 || bus.mem_done !== 1'b1 || bus.mem_err !== 1'b1 ||
        bus.BusMuxInMDR !== exp_v) begin
      n_fail++;
      $display("FAIL timeout_fire: req=%b done=%b err=%b mdr=%h, want 0/1/1/%h",
               bus.mem_req, bus.mem_done, bus.mem_err, bus.BusMuxInMDR, exp_v);
    end
    step();
    step();
    n_checks++;
    if (bus.mem_err !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b, want 1", bus.mem_err);
    end
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    step();
    bus.MemRead = 1'b1;
    exp_q.push_back(32'h600D_F00D);
    step();
    idle_inputs();
    for (int c = 1; c <= int'(TIMEOUT); c++) begin
      bus.mem_ack   = (c == int'(TIMEOUT));
      bus.mem_rdata = 32'h600D_F00D;
      step();
    end
    idle_inputs();
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.mem_done !== 1'b1 || bus.mem_err !== 1'b0 || bus.BusMuxInMDR !== exp_v) begin
      n_fail++;
      $display("FAIL ack_at_limit: done=%b err=%b mdr=%h, want 1/0/%h",
               bus.mem_done, bus.mem_err, bus.BusMuxInMDR, exp_v);
    end
`else
    for (int c = 1; c <= 20; c++) step();
    n_checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_busy !== 1'b1 || bus.mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_forever: req=%b busy=%b err=%b, want 1/1/0",
               bus.mem_req, bus.mem_busy, bus.mem_err);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0000_0077;
    step();
    idle_inputs();
    if (exp_q.size() != 0) exp_v = exp_q.pop_front();
    n_checks++;
    if (bus.mem_done !== 1'b1 || bus.BusMuxInMDR !== exp_v || bus.mem_err !== 1'b0) begin
      n_fail++;
      $display("FAIL late_ack: done=%b mdr=%h err=%b, want 1/%h/0",
               bus.mem_done, bus.BusMuxInMDR, bus.mem_err, exp_v);
    end
`endif
    step();
  endtask

  initial begin
    idle_inputs();
    exp_v = '0;
    test_reset();
    test_read();
    test_write();
    test_load_and_request();
    test_busy_block();
    test_conflict();
    test_done_state();
    test_timeout();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
